leg_instr_encoder: RTL and testbench
====================================

// Module: leg_instr_encoder
// PURPOSE
//  Encoder end of the LEG opcode format: turns decoded instruction fields into the 4-byte LEG word
//  (OPCODE, ARG1, ARG2, DEST) and streams it out one byte per beat over a valid/ready byte interface.
//  Sits between the program-builder/loader logic and program RAM; its opcode byte must be
//  consumed unchanged by the LEG decoder (IMMEDIATE1/IMMEDIATE2/CALCULATION/JUMP).
// PARAMETERS
//  UUID        0    instance identifier, passed through to sub-instances
//  NAME        ""   instance name string
//  CNT_WIDTH   16   width of instr_count and err_count
// PORTS
//  clk          in   1          single clock, all logic on rising edge
//  rst          in   1          synchronous, active-low reset (sampled on clk)
//  in_valid     in   1          instruction fields valid
//  in_ready     out  1          encoder accepts fields this cycle
//  in_is_jump   in   1          0 = calculation, 1 = conditional jump
//  in_func      in   4          ALU function (calc) or condition code 0..5 (jump)
//  in_imm1      in   1          ARG1 is immediate -> opcode bit 7
//  in_imm2      in   1          ARG2 is immediate -> opcode bit 6
//  in_arg1      in   8          ARG1 byte
//  in_arg2      in   8          ARG2 byte
//  in_dest      in   8          DEST byte (register index or jump target)
//  out_valid    out  1          out_data valid
//  out_ready    in   1          downstream accepts byte
//  out_data     out  8          instruction byte
//  out_last     out  1          high with the DEST byte (4th byte)
//  err          out  1          one-cycle pulse: illegal jump condition dropped
//  instr_count  out  CNT_WIDTH  instructions fully emitted (wraps)
//  err_count    out  CNT_WIDTH  instructions dropped (saturates at all-ones)
// BEHAVIOUR
//  - Reset (rst=0 at edge): state IDLE; out_valid=0, out_data=0, out_last=0, err=0, counts=0;
//    in_ready=0 while rst=0. Reset mid-word discards the remaining bytes, no partial count.
//  - Opcode: calc -> {imm1,imm2,2'b00,func}; jump -> {imm1,imm2,2'b10,1'b0,func[2:0]}.
//  - Jump with func>5: fields accepted, no bytes emitted, err=1 the next cycle, err_count+1, stay IDLE.
//  - Fields captured into holding regs on accept (in_valid&in_ready); inputs may change afterwards.
//  - FSM: IDLE -> OP -> A1 -> A2 -> DST -> IDLE. In OP/A1/A2/DST out_valid=1 and
//    out_data=opcode/arg1/arg2/dest; advance only on out_valid&out_ready; data stable while stalled.
//  - Latency: accept at edge N -> opcode byte valid in cycle N+1. Min 4 cycles per instruction.
//  - in_ready = (state==IDLE) | (state==DST & out_ready). Accept during DST transfer goes
//    straight to OP: back-to-back words, no bubble.
//  - out_last=1 only in DST. instr_count+1 on the DST transfer; wraps from all-ones to 0.
//  - Simultaneous DST transfer and illegal-jump accept: count+1 and err both occur; next state IDLE.
//  - out_valid never drops without a transfer (except reset).
// TESTING
//  calc func=0, imm1=1, imm2=0, arg1=5, arg2=3, dest=2, out_ready=1 -> 0x80,0x05,0x03,0x02; last on 4th; count=1
//  jump func=3, imm2=1, arg1=0x10, arg2=0x20, dest=0x40 -> opcode 0x63; decoder gives JUMP=1, IMMEDIATE2=1
//  jump func=6 -> no out_valid, err pulse 1 cycle, err_count=1; next legal word emits normally
//  out_ready low 3 cycles during A1 -> out_data holds arg1, out_valid stays 1, no byte lost or repeated
//  two words with in_valid held, out_ready=1 -> 8 consecutive beats, no gap; count=2
//  rst=0 after 2nd byte -> next cycle out_valid=0, count unchanged; new word after reset starts at OP

Source files
------------

// File: rtl/leg_instr_encoder.sv
// leg_instr_encoder: packs decoded LEG instruction fields into the 4-byte
// word OPCODE, ARG1, ARG2, DEST and streams it one byte per beat over a
// valid/ready byte interface. Illegal jump conditions are dropped and counted.
module leg_instr_encoder #(
  parameter int    UUID      = 0,
  parameter string NAME      = "",
  parameter int    CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_is_jump,
  input  logic [3:0]           in_func,
  input  logic                 in_imm1,
  input  logic                 in_imm2,
  input  logic [7:0]           in_arg1,
  input  logic [7:0]           in_arg2,
  input  logic [7:0]           in_dest,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           out_data,
  output logic                 out_last,
  output logic                 err,
  output logic [CNT_WIDTH-1:0] instr_count,
  output logic [CNT_WIDTH-1:0] err_count
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_OP   = 3'd1,
    S_A1   = 3'd2,
    S_A2   = 3'd3,
    S_DST  = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic                 err_q, err_d;
  logic [CNT_WIDTH-1:0] instr_cnt_q, instr_cnt_d;
  logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

  // Holding registers for the captured word; loaded only on accept.
  logic [7:0]           op_q, arg1_q, arg2_q, dest_q;

  logic                 accept;
  logic                 drop;

  // Instance identity is informational only; folded here so it is referenced.
  logic                 unused_params;
  assign unused_params = (UUID != 0) || (NAME != "");

  // Opcode byte as the LEG decoder expects it: bit7/bit6 immediates,
  // bit5 selects jump, calc keeps the full 4-bit function in the low nibble.
  function automatic logic [7:0] make_opcode(input logic       is_jump,
                                             input logic       imm1,
                                             input logic       imm2,
                                             input logic [3:0] func);
    if (is_jump) begin
      return {imm1, imm2, 2'b10, 1'b0, func[2:0]};
    end
    return {imm1, imm2, 2'b00, func};
  endfunction

  // Jump conditions are defined only for codes 0..5.
  function automatic logic is_illegal(input logic       is_jump,
                                      input logic [3:0] func);
    return is_jump && (func > 4'd5);
  endfunction

  // Ready when idle, or when the last byte leaves this cycle so the next
  // word can follow with no bubble. Held low throughout reset.
  assign in_ready = rst && ((state_q == S_IDLE) ||
                            ((state_q == S_DST) && out_ready));
  assign accept   = in_valid && in_ready;
  assign drop     = accept && is_illegal(in_is_jump, in_func);

  // Next-state, byte mux and counter updates.
  always_comb begin
    state_d     = state_q;
    err_d       = 1'b0;
    instr_cnt_d = instr_cnt_q;
    err_cnt_d   = err_cnt_q;
    out_valid   = 1'b0;
    out_data    = 8'h00;
    out_last    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept && !drop) state_d = S_OP;
      end
      S_OP: begin
        out_valid = 1'b1;
        out_data  = op_q;
        if (out_ready) state_d = S_A1;
      end
      S_A1: begin
        out_valid = 1'b1;
        out_data  = arg1_q;
        if (out_ready) state_d = S_A2;
      end
      S_A2: begin
        out_valid = 1'b1;
        out_data  = arg2_q;
        if (out_ready) state_d = S_DST;
      end
      S_DST: begin
        out_valid = 1'b1;
        out_data  = dest_q;
        out_last  = 1'b1;
        if (out_ready) begin
          instr_cnt_d = instr_cnt_q + CNT_WIDTH'(1);
          state_d     = (accept && !drop) ? S_OP : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A dropped word never leaves IDLE/DST bookkeeping; it only flags.
    if (drop) begin
      err_d = 1'b1;
      if (err_cnt_q != {CNT_WIDTH{1'b1}}) err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
    end
  end

  // Control state and counters with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      err_q       <= 1'b0;
      instr_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      err_q       <= err_d;
      instr_cnt_q <= instr_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // Capture the word on accept so the source may change fields afterwards.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= make_opcode(in_is_jump, in_imm1, in_imm2, in_func);
      arg1_q <= in_arg1;
      arg2_q <= in_arg2;
      dest_q <= in_dest;
    end
  end

  assign err         = err_q;
  assign instr_count = instr_cnt_q;
  assign err_count   = err_cnt_q;

endmodule

// File: tb/tb_leg_instr_encoder.sv
// Testbench for leg_instr_encoder: directed scenarios plus randomized traffic
// checked against a byte-queue reference model of the instruction stream.
module tb_leg_instr_encoder;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          in_is_jump;
  logic [3:0]    in_func;
  logic          in_imm1;
  logic          in_imm2;
  logic [7:0]    in_arg1;
  logic [7:0]    in_arg2;
  logic [7:0]    in_dest;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_data;
  logic          out_last;
  logic          err;
  logic [CW-1:0] instr_count;
  logic [CW-1:0] err_count;

  leg_instr_encoder #(.UUID(1), .NAME("enc0"), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_is_jump(in_is_jump), .in_func(in_func),
    .in_imm1(in_imm1), .in_imm2(in_imm2),
    .in_arg1(in_arg1), .in_arg2(in_arg2), .in_dest(in_dest),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last),
    .err(err), .instr_count(instr_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Reference model: bytes still owed downstream, expected counters/flags.
  logic [7:0]    exp_q[$];
  logic [7:0]    obs_q[$];
  logic [CW-1:0] m_cnt;
  logic [CW-1:0] m_errc;
  logic          m_err;
  bit            last_acc;
  int            n_chk;
  int            n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_opcode(input bit j, input int f, input bit i1, input bit i2);
    int v;
    v = i1 * 128 + i2 * 64 + (j ? 32 + f : f);
    return v[7:0];
  endfunction

  function automatic logic [31:0] obs_at(input int i);
    if (i < obs_q.size()) return {24'h0, obs_q[i]};
    return 32'hFFFF;
  endfunction

  // One clock: check outputs at the falling edge, advance the model for the
  // coming rising edge, then return just after that edge.
  task automatic cycle();
    logic exp_rdy;
    logic nerr;
    @(negedge clk);
    exp_rdy = rst && (exp_q.size() == 0 || (exp_q.size() == 1 && out_ready));
    check("out_valid", out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      check("out_data", out_data, exp_q[0]);
      check("out_last", out_last, exp_q.size() == 1);
    end else begin
      check("out_data_idle", out_data, 0);
      check("out_last_idle", out_last, 0);
    end
    check("err", err, m_err);
    check("instr_count", instr_count, m_cnt);
    check("err_count", err_count, m_errc);
    check("in_ready", in_ready, exp_rdy);
    last_acc = 0;
    if (!rst) begin
      exp_q.delete();
      m_cnt  = '0;
      m_errc = '0;
      m_err  = 1'b0;
    end else begin
      nerr = 1'b0;
      if (exp_q.size() != 0 && out_ready) begin
        obs_q.push_back(out_data);
        if (exp_q.size() == 1) m_cnt++;
        void'(exp_q.pop_front());
      end
      if (in_valid && exp_rdy) begin
        last_acc = 1;
        if (in_is_jump && in_func > 5) begin
          nerr = 1'b1;
          if (m_errc != {CW{1'b1}}) m_errc++;
        end else begin
          exp_q.push_back(ref_opcode(in_is_jump, int'(in_func), in_imm1, in_imm2));
          exp_q.push_back(in_arg1);
          exp_q.push_back(in_arg2);
          exp_q.push_back(in_dest);
        end
      end
      m_err = nerr;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit j, input logic [3:0] f, input bit i1, input bit i2,
                      input logic [7:0] a1, input logic [7:0] a2, input logic [7:0] d);
    in_is_jump = j; in_func = f; in_imm1 = i1; in_imm2 = i2;
    in_arg1 = a1; in_arg2 = a2; in_dest = d;
    in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      cycle();
      if (last_acc) break;
    end
    if (!last_acc) check("accept_timeout", 0, 1);
    in_valid   = 1'b0;
    in_is_jump = 1'($urandom);
    in_func    = 4'($urandom);
    in_arg1    = 8'($urandom);
    in_arg2    = 8'($urandom);
    in_dest    = 8'($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CW-1:0] c0;
    n_chk = 0; n_fail = 0;
    m_cnt = '0; m_errc = '0; m_err = 1'b0;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_is_jump = 1'b0; in_func = 4'h0; in_imm1 = 1'b0; in_imm2 = 1'b0;
    in_arg1 = 8'h00; in_arg2 = 8'h00; in_dest = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    cycle();
    rst = 1'b1;
    cycle();

    // Calculation word with ARG1 immediate.
    obs_q.delete();
    send(0, 4'd0, 1, 0, 8'h05, 8'h03, 8'h02);
    repeat (5) cycle();
    check("calc_nbytes", obs_q.size(), 4);
    check("calc_op", obs_at(0), 8'h80);
    check("calc_a1", obs_at(1), 8'h05);
    check("calc_a2", obs_at(2), 8'h03);
    check("calc_dst", obs_at(3), 8'h02);
    check("calc_count", instr_count, 1);

    // Conditional jump with ARG2 immediate.
    obs_q.delete();
    send(1, 4'd3, 0, 1, 8'h10, 8'h20, 8'h40);
    repeat (5) cycle();
    check("jump_op", obs_at(0), 8'h63);
    check("jump_bit5", obs_at(0) >> 5 & 1, 1);
    check("jump_bit6", obs_at(0) >> 6 & 1, 1);
    check("jump_dst", obs_at(3), 8'h40);

    // Illegal jump condition is dropped and flagged for one cycle.
    obs_q.delete();
    send(1, 4'd6, 1, 1, 8'h11, 8'h22, 8'h33);
    check("err_pulse", err, 1);
    cycle();
    check("err_one_cycle", err, 0);
    check("err_count1", err_count, 1);
    repeat (3) cycle();
    check("drop_nbytes", obs_q.size(), 0);
    send(0, 4'd7, 0, 0, 8'h44, 8'h55, 8'h66);
    repeat (5) cycle();
    check("after_drop_op", obs_at(0), 8'h07);
    check("after_drop_n", obs_q.size(), 4);

    // Downstream stall while ARG1 is on the bus.
    obs_q.delete();
    send(0, 4'd2, 0, 0, 8'hAA, 8'hBB, 8'hCC);
    cycle();
    out_ready = 1'b0;
    repeat (3) cycle();
    check("stall_data", out_data, 8'hAA);
    check("stall_valid", out_valid, 1);
    out_ready = 1'b1;
    repeat (4) cycle();
    check("stall_nbytes", obs_q.size(), 4);
    check("stall_a1", obs_at(1), 8'hAA);
    check("stall_a2", obs_at(2), 8'hBB);

    // Back-to-back words with no bubble.
    obs_q.delete();
    c0 = instr_count;
    send(0, 4'd1, 0, 0, 8'h01, 8'h02, 8'h03);
    send(1, 4'd5, 1, 0, 8'h04, 8'h05, 8'h06);
    repeat (4) cycle();
    check("b2b_nbytes", obs_q.size(), 8);
    check("b2b_op2", obs_at(4), 8'hA5);
    check("b2b_count", instr_count, c0 + CW'(2));

    // Reset after the second byte abandons the word.
    obs_q.delete();
    send(0, 4'd4, 0, 0, 8'h12, 8'h34, 8'h56);
    repeat (2) cycle();
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    check("rst_valid", out_valid, 0);
    check("rst_count", instr_count, 0);
    obs_q.delete();
    send(0, 4'd1, 0, 0, 8'h09, 8'h08, 8'h07);
    repeat (5) cycle();
    check("post_rst_op", obs_at(0), 8'h01);
    check("post_rst_n", obs_q.size(), 4);

    // Randomized traffic with backpressure, illegal jumps and rare resets.
    for (int i = 0; i < 1200; i++) begin
      rst        = ($urandom_range(0, 199) != 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      in_valid   = 1'($urandom);
      in_is_jump = 1'($urandom);
      in_func    = 4'($urandom_range(0, 15));
      in_imm1    = 1'($urandom);
      in_imm2    = 1'($urandom);
      in_arg1    = 8'($urandom);
      in_arg2    = 8'($urandom);
      in_dest    = 8'($urandom);
      cycle();
    end
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) cycle();

    // Counter limits: err_count saturates, instr_count wraps.
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    for (int i = 0; i < 17; i++) send(1, 4'd15, 0, 0, 8'h00, 8'h00, 8'h00);
    cycle();
    check("err_saturate", err_count, {CW{1'b1}});
    for (int i = 0; i < 17; i++) send(0, 4'(i), 0, 0, 8'(i), 8'h00, 8'hFF);
    repeat (5) cycle();
    check("count_wrap", instr_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
